// File: rtl/chr_overlay_if.sv
// chr_overlay_if: pixel stream in/out plus the font ROM lookup.
// slave = overlay controller side, master = pipeline/ROM side.
interface chr_overlay_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_enable;
  logic [DATA_WIDTH-1:0] in_data;
  logic [7:0]            font_index;
  logic [63:0]           font_result;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave (
    input  in_enable,
    input  in_data,
    input  font_result,
    output font_index,
    output out_ready,
    output out_data
  );

  modport master (
    output in_enable,
    output in_data,
    output font_result,
    input  font_index,
    input  out_ready,
    input  out_data
  );
endinterface

// File: rtl/chr_overlay_ctrl.sv
// chr_overlay_ctrl: 8x8 font text overlay on a raster pixel stream.
// Define CHR_OVERLAY_BG_EN to add bg_color and draw an opaque box.
module chr_overlay_ctrl #(
  parameter int IM_WIDTH   = 640,
  parameter int IM_HEIGHT  = 480,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_CHARS  = 16,
  parameter int W_IDX      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [W_IDX-1:0]      cfg_addr,
  input  logic [7:0]            cfg_char,
  input  logic [15:0]           txt_x,
  input  logic [15:0]           txt_y,
  input  logic [W_IDX:0]        txt_len,
  input  logic [DATA_WIDTH-1:0] fg_color,
`ifdef CHR_OVERLAY_BG_EN
  input  logic [DATA_WIDTH-1:0] bg_color,
`endif
  chr_overlay_if.slave          pix
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [15:0] X_LAST = 16'(IM_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IM_HEIGHT - 1);

  state_t r_state;
  state_t w_state_nx;

  logic [15:0]     r_x;
  logic [15:0]     r_y;
  logic [15:0]     r_sx;
  logic [15:0]     r_sy;
  logic [W_IDX:0]  r_slen;
  logic [7:0]      r_buf [MAX_CHARS];

  logic            w_load;
  logic            w_xend;
  logic            w_yend;
  logic [15:0]     w_sx;
  logic [15:0]     w_sy;
  logic [W_IDX:0]  w_slen;
  logic [16:0]     w_dx;
  logic [16:0]     w_dy;
  logic [16:0]     w_wlim;
  logic            w_hit;
  logic [W_IDX-1:0] w_ci;
  logic [7:0]      w_chr;
  logic [7:0]      w_idx;

  logic [7:0]            r_idx;
  logic [2:0]            r_row;
  logic [2:0]            r_col;
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_pix;
  logic                  r_v1;

  logic                  w_bit;
  logic [DATA_WIDTH-1:0] w_out;
  logic                  r_rdy;
  logic [DATA_WIDTH-1:0] r_dat;

  assign w_xend = (r_x == X_LAST);
  assign w_yend = (r_y == Y_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (pix.in_enable) begin
          w_state_nx = S_RUN;
          w_load     = 1'b1;
        end
      end
      S_RUN: begin
        if (pix.in_enable && w_xend && w_yend)
          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // The first pixel of a frame already sees the config being latched.
  assign w_sx   = w_load ? txt_x   : r_sx;
  assign w_sy   = w_load ? txt_y   : r_sy;
  assign w_slen = w_load ? txt_len : r_slen;

  assign w_dx   = {1'b0, r_x} - {1'b0, w_sx};
  assign w_dy   = {1'b0, r_y} - {1'b0, w_sy};
  assign w_wlim = 17'({w_slen, 3'b000});
  assign w_hit  = (w_dy < 17'd8) && (w_dx < w_wlim);
  assign w_ci   = w_dx[W_IDX+2:3];
  assign w_chr  = r_buf[w_ci];
  assign w_idx  = (w_chr >= 8'h20 && w_chr <= 8'h7E)
                ? w_chr : 8'h20;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_sx   <= '0;
      r_sy   <= '0;
      r_slen <= '0;
    end else begin
      if (w_load) begin
        r_sx   <= txt_x;
        r_sy   <= txt_y;
        r_slen <= txt_len;
      end
      if (pix.in_enable) begin
        if (w_xend) begin
          r_x <= '0;
          r_y <= w_yend ? 16'd0 : r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHARS; i++)
        r_buf[i] <= 8'h20;
    end else if (cfg_we) begin
      r_buf[cfg_addr] <= cfg_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 8'h20;
      r_row <= '0;
      r_col <= '0;
      r_hit <= 1'b0;
      r_pix <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= pix.in_enable;
      if (pix.in_enable) begin
        r_idx <= w_hit ? w_idx : 8'h20;
        r_row <= w_dy[2:0];
        r_col <= w_dx[2:0];
        r_hit <= w_hit;
        r_pix <= pix.in_data;
      end
    end
  end

  // Bit 63-8r-c is the 6-bit complement of {r,c}.
  assign w_bit = pix.font_result[{~r_row, ~r_col}];

`ifdef CHR_OVERLAY_BG_EN
  assign w_out = !r_hit ? r_pix
               : (w_bit ? bg_color : fg_color);
`else
  assign w_out = (r_hit && !w_bit) ? fg_color : r_pix;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy <= 1'b0;
      r_dat <= '0;
    end else begin
      r_rdy <= r_v1;
      if (r_v1) r_dat <= w_out;
    end
  end

  assign pix.font_index = r_idx;
  assign pix.out_ready  = r_rdy;
  assign pix.out_data   = r_dat;

endmodule
